// File: rtl/decode_pkg.sv
// Shared constants and the decoded-control bundle for the MIPS decode stage.
package decode_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef struct packed {
        logic [3:0] op;
        logic       ssel;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       branch;
        logic       illegal;
        logic [4:0] rdst;
    } ctrl_t;

    // Idle/reset contents of the output register: undefined ALU op, no side effects.
    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c    = '0;
        c.op = ALU_BAD;
        return c;
    endfunction

endpackage

// File: rtl/decode_core.sv
// Purely combinational instruction decode: ALU op, operand select, control bits and immediate.
module decode_core
    import decode_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int LOGIC_ZX = 1
) (
    input  logic [DWIDTH-1:0] instr,
    output ctrl_t             ctrl,
    output logic [DWIDTH-1:0] imm,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic              uses_rs2
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic              use_imm;
    logic              zero_ext;
    logic [DWIDTH-1:0] imm_sx;
    logic [DWIDTH-1:0] imm_zx;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rs1    = instr[25:21];
    assign rs2    = instr[20:16];
    assign imm_sx = {{(DWIDTH-16){instr[15]}}, instr[15:0]};
    assign imm_zx = {{(DWIDTH-16){1'b0}}, instr[15:0]};
    assign imm    = use_imm ? (zero_ext ? imm_zx : imm_sx) : '0;

    always_comb begin
        ctrl         = ctrl_reset();
        ctrl.illegal = 1'b1;
        uses_rs2     = 1'b0;
        use_imm      = 1'b0;
        zero_ext     = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                uses_rs2 = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.op = ALU_ADD;
                    FN_SUB:  ctrl.op = ALU_SUB;
                    FN_AND:  ctrl.op = ALU_AND;
                    FN_OR:   ctrl.op = ALU_OR;
                    FN_NOR:  ctrl.op = ALU_NOR;
                    FN_SLT:  ctrl.op = ALU_SLT;
                    default: ctrl.op = ALU_BAD;
                endcase
                if (ctrl.op != ALU_BAD) begin
                    ctrl.illegal = 1'b0;
                    ctrl.ssel    = 1'b1;
                    ctrl.reg_we  = 1'b1;
                    ctrl.rdst    = instr[15:11];
                end
            end
            OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI, OPC_LW: begin
                ctrl.illegal = 1'b0;
                ctrl.reg_we  = 1'b1;
                ctrl.rdst    = instr[20:16];
                use_imm      = 1'b1;
                case (opcode)
                    OPC_SLTI: ctrl.op = ALU_SLT;
                    OPC_ANDI: begin
                        ctrl.op  = ALU_AND;
                        zero_ext = (LOGIC_ZX != 0);
                    end
                    OPC_ORI: begin
                        ctrl.op  = ALU_OR;
                        zero_ext = (LOGIC_ZX != 0);
                    end
                    OPC_LW: begin
                        ctrl.op     = ALU_ADD;
                        ctrl.mem_re = 1'b1;
                    end
                    default:  ctrl.op = ALU_ADD;
                endcase
            end
            OPC_SW: begin
                ctrl.illegal = 1'b0;
                ctrl.op      = ALU_ADD;
                ctrl.mem_we  = 1'b1;
                use_imm      = 1'b1;
                uses_rs2     = 1'b1;
            end
            OPC_BEQ: begin
                ctrl.illegal = 1'b0;
                ctrl.op      = ALU_SUB;
                ctrl.ssel    = 1'b1;
                ctrl.branch  = 1'b1;
                uses_rs2     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, load-use hazard bubble and saturating stall counter.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int LOGIC_ZX = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        op,
    output logic              ssel,
    output logic [DWIDTH-1:0] imm,
    output logic [4:0]        rs1_id,
    output logic [4:0]        rs2_id,
    output logic [4:0]        rdst_id,
    output logic              reg_we,
    output logic              mem_re,
    output logic              mem_we,
    output logic              branch,
    output logic              illegal,
    output logic [CNT_W-1:0]  stall_cnt
);

    ctrl_t             dec_ctrl;
    logic [DWIDTH-1:0] dec_imm;
    logic [4:0]        dec_rs1;
    logic [4:0]        dec_rs2;
    logic              dec_uses_rs2;

    ctrl_t             ctrl_q;
    logic [DWIDTH-1:0] imm_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;

    logic hazard;
    logic fire_in;
    logic fire_out;

    decode_core #(
        .DWIDTH   (DWIDTH),
        .LOGIC_ZX (LOGIC_ZX)
    ) u_core (
        .instr    (instr),
        .ctrl     (dec_ctrl),
        .imm      (dec_imm),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .uses_rs2 (dec_uses_rs2)
    );

    // Incoming instr reads a register the held load has not yet produced.
    assign hazard = out_valid & ctrl_q.mem_re & (ctrl_q.rdst != 5'd0) &
                    ((dec_rs1 == ctrl_q.rdst) | (dec_uses_rs2 & (dec_rs2 == ctrl_q.rdst)));

    assign in_ready = !flush & !hazard & (!out_valid | out_ready);
    assign fire_in  = in_valid & in_ready;
    assign fire_out = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ctrl_q    <= ctrl_reset();
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire_in) begin
            out_valid <= 1'b1;
            ctrl_q    <= dec_ctrl;
            imm_q     <= dec_imm;
            rs1_q     <= dec_rs1;
            rs2_q     <= dec_rs2;
        end else if (fire_out) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && !flush && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign op      = ctrl_q.op;
    assign ssel    = ctrl_q.ssel;
    assign imm     = imm_q;
    assign rs1_id  = rs1_q;
    assign rs2_id  = rs2_q;
    assign rdst_id = ctrl_q.rdst;
    assign reg_we  = ctrl_q.reg_we;
    assign mem_re  = ctrl_q.mem_re;
    assign mem_we  = ctrl_q.mem_we;
    assign branch  = ctrl_q.branch;
    assign illegal = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: scoreboard of independently decoded expectations plus handshake/hazard checks.
module tb_decode_stage;

    localparam int CW = 4;

    typedef struct packed {
        logic [3:0]  op;
        logic        ssel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rdst;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        illegal;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    op;
    logic          ssel;
    logic [31:0]   imm;
    logic [4:0]    rs1_id;
    logic [4:0]    rs2_id;
    logic [4:0]    rdst_id;
    logic          reg_we;
    logic          mem_re;
    logic          mem_we;
    logic          branch;
    logic          illegal;
    logic [CW-1:0] stall_cnt;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t got;

    assign got = {op, ssel, imm, rs1_id, rs2_id, rdst_id, reg_we, mem_re, mem_we, branch, illegal};

    always #5 clk = ~clk;

    decode_stage #(.DWIDTH(32), .LOGIC_ZX(1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .op(op), .ssel(ssel),
        .imm(imm), .rs1_id(rs1_id), .rs2_id(rs2_id), .rdst_id(rdst_id), .reg_we(reg_we),
        .mem_re(mem_re), .mem_we(mem_we), .branch(branch), .illegal(illegal), .stall_cnt(stall_cnt)
    );

    function automatic exp_t model(input logic [31:0] w);
        exp_t        e;
        logic [31:0] sx;
        logic [31:0] zx;
        sx    = {{16{w[15]}}, w[15:0]};
        zx    = {16'h0000, w[15:0]};
        e     = '0;
        e.rs1 = w[25:21];
        e.rs2 = w[20:16];
        e.op  = 4'b1111;
        case (w[31:26])
            6'h00: begin
                case (w[5:0])
                    6'h20: e.op = 4'b0010;
                    6'h22: e.op = 4'b0110;
                    6'h24: e.op = 4'b0000;
                    6'h25: e.op = 4'b0001;
                    6'h27: e.op = 4'b1100;
                    6'h2A: e.op = 4'b0111;
                    default: e.op = 4'b1111;
                endcase
                if (e.op == 4'b1111) e.illegal = 1'b1;
                else begin e.ssel = 1'b1; e.reg_we = 1'b1; e.rdst = w[15:11]; end
            end
            6'h08: begin e.op = 4'b0010; e.imm = sx; e.reg_we = 1'b1; e.rdst = w[20:16]; end
            6'h0A: begin e.op = 4'b0111; e.imm = sx; e.reg_we = 1'b1; e.rdst = w[20:16]; end
            6'h0C: begin e.op = 4'b0000; e.imm = zx; e.reg_we = 1'b1; e.rdst = w[20:16]; end
            6'h0D: begin e.op = 4'b0001; e.imm = zx; e.reg_we = 1'b1; e.rdst = w[20:16]; end
            6'h23: begin e.op = 4'b0010; e.imm = sx; e.reg_we = 1'b1; e.mem_re = 1'b1; e.rdst = w[20:16]; end
            6'h2B: begin e.op = 4'b0010; e.imm = sx; e.mem_we = 1'b1; end
            6'h04: begin e.op = 4'b0110; e.ssel = 1'b1; e.branch = 1'b1; end
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard: push on accepted input, pop on downstream transfer; flush drops the held entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && flush) begin
                if (sb.size() > 0) void'(sb.pop_front());
            end else if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_underflow: output %h with nothing expected", got);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL sb_fields: got %h expected %h", got, e);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(instr));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic send(input logic [31:0] w, output int waits);
        logic acc;
        acc      = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        instr    = w;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            acc = in_ready;
            cyc();
            waits++;
            if (acc) break;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout: instr %h not accepted in %0d cycles", w, waits);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b1;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        total++; if (op !== 4'b1111) begin bad++; $display("FAIL rst_op: got %b want 1111", op); end
        total++; if ({ssel, imm, rs1_id, rs2_id, rdst_id, reg_we, mem_re, mem_we, branch, illegal} !== '0)
            begin bad++; $display("FAIL rst_fields: nonzero field bundle"); end
        total++; if (stall_cnt !== '0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        #5 rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_add();
        int w;
        send(32'h00221820, w);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", out_valid); end
        total++; if ({op, ssel, rdst_id, reg_we} !== {4'b0010, 1'b1, 5'd3, 1'b1})
            begin bad++; $display("FAIL add_fields: op=%b ssel=%b rdst=%0d we=%b want 0010 1 3 1", op, ssel, rdst_id, reg_we); end
        idle(2);
    endtask

    task automatic test_imm_ext();
        int w;
        send(32'h30A48001, w);
        total++; if (imm !== 32'h00008001) begin bad++; $display("FAIL andi_imm: got %h want 00008001", imm); end
        send(32'h20A48001, w);
        total++; if (imm !== 32'hFFFF8001) begin bad++; $display("FAIL addi_imm: got %h want ffff8001", imm); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [31:0]   prog [8];
        logic [CW-1:0] s0;
        int            w;
        prog = '{32'h00C72822, 32'h00430827, 32'h014B4824, 32'h2862FFFF,
                 32'h10220010, 32'h3426F0F0, 32'h8D200000, 32'h00005020};
        s0 = stall_cnt;
        for (int i = 0; i < 8; i++) begin
            send(prog[i], w);
            total++; if (w !== 1) begin bad++; $display("FAIL b2b_rate[%0d]: took %0d cycles want 1", i, w); end
        end
        idle(2);
        total++; if (stall_cnt !== s0) begin bad++; $display("FAIL lw0_nostall: cnt %0d want %0d", stall_cnt, s0); end
    endtask

    task automatic test_load_use();
        logic [CW-1:0] s0;
        int            w;
        s0 = stall_cnt;
        send(32'h8D280000, w);
        instr = 32'h01085020;
        @(negedge clk);
        total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL lu_hold: valid/ready %b%b want 10", out_valid, in_ready); end
        cyc();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble: valid %b want 0", out_valid); end
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_accept: in_ready %b want 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        total++; if ({out_valid, rdst_id} !== {1'b1, 5'd10}) begin bad++; $display("FAIL lu_out: valid=%b rdst=%0d want 1 10", out_valid, rdst_id); end
        total++; if (stall_cnt !== s0 + CW'(1)) begin bad++; $display("FAIL lu_cnt: cnt %0d want %0d", stall_cnt, s0 + CW'(1)); end
        idle(2);
        s0 = stall_cnt;
        send(32'h8D270000, w);
        send(32'hAC270004, w);
        total++; if (w !== 2) begin bad++; $display("FAIL sw_stall: took %0d cycles want 2", w); end
        total++; if (stall_cnt !== s0 + CW'(1)) begin bad++; $display("FAIL sw_cnt: cnt %0d want %0d", stall_cnt, s0 + CW'(1)); end
        idle(2);
    endtask

    task automatic test_flush();
        logic [CW-1:0] s0;
        int            w;
        out_ready = 1'b0;
        send(32'h8D280000, w);
        instr = 32'h01085020;
        s0    = stall_cnt;
        flush = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: in_ready %b want 0", in_ready); end
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: valid %b want 0", out_valid); end
        total++; if (stall_cnt !== s0) begin bad++; $display("FAIL flush_cnt: cnt %0d want %0d", stall_cnt, s0); end
        idle(2);
    endtask

    task automatic test_backpressure();
        exp_t snap;
        int   w;
        out_ready = 1'b0;
        send(32'h0022183F, w);
        total++; if ({op, illegal} !== {4'b1111, 1'b1}) begin bad++; $display("FAIL illegal_fn: op=%b ill=%b want 1111 1", op, illegal); end
        snap  = got;
        instr = 32'h3426F0F0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({out_valid, in_ready} !== 2'b10 || got !== snap) begin
                bad++; $display("FAIL bp_hold[%0d]: valid/ready %b%b fields %h want 10 %h", i, out_valid, in_ready, got, snap);
            end
            cyc();
        end
        out_ready = 1'b1;
        send(32'h3426F0F0, w);
        total++; if (w !== 1) begin bad++; $display("FAIL bp_release: took %0d cycles want 1", w); end
        idle(2);
    endtask

    task automatic test_saturate();
        int w;
        out_ready = 1'b0;
        send(32'h8D280000, w);
        instr = 32'h01085020;
        repeat (20) cyc();
        total++; if (stall_cnt !== {CW{1'b1}}) begin bad++; $display("FAIL cnt_sat: cnt %0d want %0d", stall_cnt, {CW{1'b1}}); end
        out_ready = 1'b1;
        send(32'h01085020, w);
        idle(3);
    endtask

    task automatic test_reset_mid();
        int w;
        out_ready = 1'b0;
        send(32'h00221820, w);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({out_valid, op, rdst_id, reg_we, ssel, stall_cnt} !== {1'b0, 4'b1111, 5'd0, 1'b0, 1'b0, {CW{1'b0}}})
            begin bad++; $display("FAIL mid_rst: valid=%b op=%b rdst=%0d we=%b cnt=%0d", out_valid, op, rdst_id, reg_we, stall_cnt); end
        in_valid = 1'b0; out_ready = 1'b1;
        #4 rst_n = 1'b1;
        cyc();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_drop: valid %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm_ext();
        test_back_to_back();
        test_load_use();
        test_flush();
        test_backpressure();
        test_saturate();
        test_reset_mid();
        idle(2);
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: %0d entries never produced", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
